// File: rtl/cp0_pkg.sv
// Shared cp0 types: exception/TLB fault encodings, cp0 command type and the
// per-lane commit bundle used by the exception arbiter.
package cp0_pkg;

  typedef struct packed {
    logic badVaddrF;
    logic reserved;
    logic syscall;
    logic breakpoint;
    logic overflow;
    logic badVaddrL;
    logic badVaddrS;
  } excp_type_t;

  typedef struct packed {
    logic refill;
    logic invalid;
    logic modified;
  } tlb_exc_t;

  typedef enum logic {
    NONE      = 1'b0,
    EXCEPTION = 1'b1
  } cp0_type_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_INT,
    EV_ERET
  } commit_event_t;

  typedef enum logic {
    RUN,
    DRAIN
  } commit_state_t;

  typedef struct packed {
    logic       valid;
    logic [31:0] pc;
    logic       branch;
    logic       eret;
    excp_type_t etype;
    tlb_exc_t   itlb;
    tlb_exc_t   dtlb;
    logic       dwrite;
    logic [31:0] vaddr;
  } lane_exc_t;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_MOD  = 5'h01;
  localparam logic [4:0] EXCCODE_TLBL = 5'h02;
  localparam logic [4:0] EXCCODE_TLBS = 5'h03;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  // Fetch faults outrank decode faults, which outrank data-side faults.
  function automatic logic [4:0] exccode(excp_type_t e, tlb_exc_t it,
                                         tlb_exc_t dt, logic dwrite);
    logic [4:0] code;
    code = EXCCODE_INT;
    if (e.badVaddrF)                code = EXCCODE_ADEL;
    else if (|it)                   code = EXCCODE_TLBL;
    else if (e.reserved)            code = EXCCODE_RI;
    else if (e.syscall)             code = EXCCODE_SYS;
    else if (e.breakpoint)          code = EXCCODE_BP;
    else if (e.overflow)            code = EXCCODE_OV;
    else if (e.badVaddrL)           code = EXCCODE_ADEL;
    else if (e.badVaddrS)           code = EXCCODE_ADES;
    else if (dt.modified)           code = EXCCODE_MOD;
    else if (dt.refill | dt.invalid) code = dwrite ? EXCCODE_TLBS : EXCCODE_TLBL;
    return code;
  endfunction

endpackage

// File: rtl/excp_commit_if.sv
// Memory-stage lanes in, cp0 exception bundle and commit/flush out.
interface excp_commit_if import cp0_pkg::*; ();

  logic              stall;
  logic [1:0]        lane_valid;
  logic [1:0][31:0]  lane_pc;
  logic [1:0]        lane_branch;
  logic [1:0]        lane_eret;
  excp_type_t [1:0]  lane_etype;
  tlb_exc_t [1:0]    lane_itlb;
  tlb_exc_t [1:0]    lane_dtlb;
  logic [1:0]        lane_dwrite;
  logic [1:0][31:0]  lane_vaddr;
  logic              is_int;
  logic [31:0]       entrance;
  logic [31:0]       epc;

  cp0_type_t         ctype;
  excp_type_t        etype;
  logic [31:0]       pc;
  logic [31:0]       vaddr;
  logic              is_slot;
  logic              d_write;
  logic              is_eret;
  tlb_exc_t          i_tlb_exc;
  tlb_exc_t          d_tlb_exc;
  logic              inter_valid;
  logic              int_slot;
  logic [31:0]       int_pc;
  logic [1:0]        commit;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic [31:0]       last_pc;

  modport master (
    output stall, lane_valid, lane_pc, lane_branch, lane_eret, lane_etype,
           lane_itlb, lane_dtlb, lane_dwrite, lane_vaddr, is_int, entrance, epc,
    input  ctype, etype, pc, vaddr, is_slot, d_write, is_eret, i_tlb_exc,
           d_tlb_exc, inter_valid, int_slot, int_pc, commit, flush,
           redirect_pc, last_pc
  );

  modport slave (
    input  stall, lane_valid, lane_pc, lane_branch, lane_eret, lane_etype,
           lane_itlb, lane_dtlb, lane_dwrite, lane_vaddr, is_int, entrance, epc,
    output ctype, etype, pc, vaddr, is_slot, d_write, is_eret, i_tlb_exc,
           d_tlb_exc, inter_valid, int_slot, int_pc, commit, flush,
           redirect_pc, last_pc
  );

endinterface

// File: rtl/exc_lane_check.sv
// Per-lane fault reduction: a valid lane excepts when any fault bit is set.
module exc_lane_check import cp0_pkg::*; (
  input  logic       valid,
  input  excp_type_t etype,
  input  tlb_exc_t   itlb,
  input  tlb_exc_t   dtlb,
  output logic       excepting
);

  assign excepting = valid & ((|etype) | (|itlb) | (|dtlb));

endmodule

// File: rtl/excp_commit.sv
// Commit-point exception arbiter: picks the oldest excepting/interruptible
// lane, produces the commit mask, and pulses the cp0 bundle plus flush.
module excp_commit import cp0_pkg::*; #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'hbfc00000
) (
  input logic         clk,
  input logic         reset,
  excp_commit_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  lane_exc_t       lane [2];
  logic [1:0]      excepting;
  commit_state_t   state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  commit_event_t   ev;
  logic            ev_lane;
  logic            ev_slot;
  logic [1:0]      commit_c;
  logic            run;
  logic            prev_branch;
  lane_exc_t       sel;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lane[i].valid  = bus.lane_valid[i];
      lane[i].pc     = bus.lane_pc[i];
      lane[i].branch = bus.lane_branch[i];
      lane[i].eret   = bus.lane_eret[i];
      lane[i].etype  = bus.lane_etype[i];
      lane[i].itlb   = bus.lane_itlb[i];
      lane[i].dtlb   = bus.lane_dtlb[i];
      lane[i].dwrite = bus.lane_dwrite[i];
      lane[i].vaddr  = bus.lane_vaddr[i];
    end
  end

  exc_lane_check u_chk0 (
    .valid(lane[0].valid), .etype(lane[0].etype), .itlb(lane[0].itlb),
    .dtlb(lane[0].dtlb), .excepting(excepting[0])
  );

  exc_lane_check u_chk1 (
    .valid(lane[1].valid), .etype(lane[1].etype), .itlb(lane[1].itlb),
    .dtlb(lane[1].dtlb), .excepting(excepting[1])
  );

  // Event arbitration: interrupt beats any fault; lane 0 is older than lane 1.
  always_comb begin
    ev         = EV_NONE;
    ev_lane    = 1'b0;
    commit_c   = 2'b00;
    state_next = state;
    cnt_next   = cnt;
    run        = reset && (state == RUN) && !bus.stall;

    if (run) begin
      if (bus.is_int && (lane[0].valid || lane[1].valid)) begin
        ev      = EV_INT;
        ev_lane = !lane[0].valid;
      end else if (excepting[0]) begin
        ev      = EV_EXC;
      end else if (excepting[1]) begin
        ev       = EV_EXC;
        ev_lane  = 1'b1;
        commit_c = {1'b0, lane[0].valid};
      end else if (lane[0].valid && lane[0].eret) begin
        ev       = EV_ERET;
        commit_c = 2'b01;
      end else if (!lane[0].valid && lane[1].valid && lane[1].eret) begin
        ev       = EV_ERET;
        ev_lane  = 1'b1;
        commit_c = 2'b10;
      end else begin
        commit_c = {lane[1].valid, lane[0].valid};
      end
    end

    case (state)
      RUN: begin
        if (ev != EV_NONE) begin
          state_next = DRAIN;
          cnt_next   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_next = RUN;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  assign bus.commit = commit_c;
  assign sel        = lane[ev_lane];
  assign ev_slot    = ev_lane ? lane[0].branch : prev_branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Delay-slot tracking follows the youngest committed lane across cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_branch <= 1'b0;
      bus.last_pc <= RESET_PC;
    end else begin
      if (ev != EV_NONE)    prev_branch <= 1'b0;
      else if (commit_c[1]) prev_branch <= lane[1].branch;
      else if (commit_c[0]) prev_branch <= lane[0].branch;

      if (commit_c[1])      bus.last_pc <= lane[1].pc;
      else if (commit_c[0]) bus.last_pc <= lane[0].pc;
    end
  end

  // Stage boundary into cp0: every field is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ctype       <= NONE;
      bus.etype       <= '0;
      bus.pc          <= '0;
      bus.vaddr       <= '0;
      bus.is_slot     <= 1'b0;
      bus.d_write     <= 1'b0;
      bus.is_eret     <= 1'b0;
      bus.i_tlb_exc   <= '0;
      bus.d_tlb_exc   <= '0;
      bus.inter_valid <= 1'b0;
      bus.int_slot    <= 1'b0;
      bus.int_pc      <= '0;
      bus.flush       <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.ctype       <= NONE;
      bus.etype       <= '0;
      bus.pc          <= '0;
      bus.vaddr       <= '0;
      bus.is_slot     <= 1'b0;
      bus.d_write     <= 1'b0;
      bus.is_eret     <= 1'b0;
      bus.i_tlb_exc   <= '0;
      bus.d_tlb_exc   <= '0;
      bus.inter_valid <= 1'b0;
      bus.int_slot    <= 1'b0;
      bus.int_pc      <= '0;
      bus.flush       <= 1'b0;
      bus.redirect_pc <= '0;
      case (ev)
        EV_EXC: begin
          bus.ctype       <= EXCEPTION;
          bus.etype       <= sel.etype;
          bus.pc          <= sel.pc;
          bus.vaddr       <= sel.vaddr;
          bus.is_slot     <= ev_slot;
          bus.d_write     <= sel.dwrite;
          bus.i_tlb_exc   <= sel.itlb;
          bus.d_tlb_exc   <= sel.dtlb;
          bus.flush       <= 1'b1;
          bus.redirect_pc <= bus.entrance;
        end
        EV_INT: begin
          bus.inter_valid <= 1'b1;
          bus.int_pc      <= sel.pc;
          bus.int_slot    <= ev_slot;
          bus.flush       <= 1'b1;
          bus.redirect_pc <= bus.entrance;
        end
        EV_ERET: begin
          bus.is_eret     <= 1'b1;
          bus.flush       <= 1'b1;
          bus.redirect_pc <= bus.epc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_excp_commit.sv
// Directed bench for excp_commit: exceptions, interrupts, eret, drain, reset.
module tb_excp_commit;
  import cp0_pkg::*;

  localparam logic [31:0] ENTRANCE = 32'hbfc00380;
  localparam logic [31:0] EPC_V    = 32'h80003000;
  localparam logic [31:0] RST_PC   = 32'hbfc00000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  excp_commit_if bus ();

  excp_commit #(.FLUSH_CYCLES(2), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic clear_lanes();
    bus.stall       = 1'b0;
    bus.is_int      = 1'b0;
    bus.lane_valid  = '0;
    bus.lane_pc     = '0;
    bus.lane_branch = '0;
    bus.lane_eret   = '0;
    bus.lane_etype  = '0;
    bus.lane_itlb   = '0;
    bus.lane_dtlb   = '0;
    bus.lane_dwrite = '0;
    bus.lane_vaddr  = '0;
  endtask

  task automatic drain();
    clear_lanes();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    clear_lanes();
    bus.entrance = ENTRANCE;
    bus.epc      = EPC_V;
    #2 reset = 1'b0;
    bus.lane_valid = 2'b11;
    repeat (2) @(negedge clk);
    checks++; if (bus.ctype !== NONE) begin errors++; $display("FAIL rst_ctype got=%0d exp=%0d", bus.ctype, NONE); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b exp=0", bus.flush); end
    checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL rst_commit got=%b exp=00", bus.commit); end
    checks++; if (bus.last_pc !== RST_PC) begin errors++; $display("FAIL rst_last_pc got=%h exp=%h", bus.last_pc, RST_PC); end
    checks++; if (bus.inter_valid !== 1'b0) begin errors++; $display("FAIL rst_inter_valid got=%b exp=0", bus.inter_valid); end
    clear_lanes();
    reset = 1'b1;
  endtask

  task automatic test_exc_lane0();
    @(negedge clk);
    bus.lane_valid = 2'b11;
    bus.lane_pc[0] = 32'h80001000;
    bus.lane_pc[1] = 32'h80001004;
    bus.lane_etype[0].syscall = 1'b1;
    #1;
    checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL exc0_commit got=%b exp=00", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.ctype !== EXCEPTION) begin errors++; $display("FAIL exc0_ctype got=%0d exp=%0d", bus.ctype, EXCEPTION); end
    checks++; if (bus.pc !== 32'h80001000) begin errors++; $display("FAIL exc0_pc got=%h exp=80001000", bus.pc); end
    checks++; if (bus.is_slot !== 1'b0) begin errors++; $display("FAIL exc0_slot got=%b exp=0", bus.is_slot); end
    checks++; if (bus.etype.syscall !== 1'b1) begin errors++; $display("FAIL exc0_syscall got=%b exp=1", bus.etype.syscall); end
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL exc0_flush got=%b exp=1", bus.flush); end
    checks++; if (bus.redirect_pc !== ENTRANCE) begin errors++; $display("FAIL exc0_redirect got=%h exp=%h", bus.redirect_pc, ENTRANCE); end
    checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL exc0_drain_commit got=%b exp=00", bus.commit); end
    drain();
    #1;
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL exc0_flush_pulse got=%b exp=0", bus.flush); end
  endtask

  task automatic test_lane1_slot();
    @(negedge clk);
    bus.lane_valid     = 2'b11;
    bus.lane_pc[0]     = 32'h80002000;
    bus.lane_branch[0] = 1'b1;
    bus.lane_pc[1]     = 32'h80002004;
    bus.lane_dtlb[1].refill = 1'b1;
    bus.lane_dwrite[1] = 1'b1;
    bus.lane_vaddr[1]  = 32'h00001234;
    #1;
    checks++; if (bus.commit !== 2'b01) begin errors++; $display("FAIL l1_commit got=%b exp=01", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.ctype !== EXCEPTION) begin errors++; $display("FAIL l1_ctype got=%0d exp=%0d", bus.ctype, EXCEPTION); end
    checks++; if (bus.pc !== 32'h80002004) begin errors++; $display("FAIL l1_pc got=%h exp=80002004", bus.pc); end
    checks++; if (bus.is_slot !== 1'b1) begin errors++; $display("FAIL l1_slot got=%b exp=1", bus.is_slot); end
    checks++; if (bus.d_tlb_exc.refill !== 1'b1) begin errors++; $display("FAIL l1_dtlb got=%b exp=1", bus.d_tlb_exc.refill); end
    checks++; if (bus.d_write !== 1'b1) begin errors++; $display("FAIL l1_dwrite got=%b exp=1", bus.d_write); end
    checks++; if (bus.vaddr !== 32'h00001234) begin errors++; $display("FAIL l1_vaddr got=%h exp=00001234", bus.vaddr); end
    checks++; if (bus.last_pc !== 32'h80002000) begin errors++; $display("FAIL l1_last_pc got=%h exp=80002000", bus.last_pc); end
    drain();
  endtask

  task automatic test_prev_branch();
    @(negedge clk);
    bus.lane_valid     = 2'b10;
    bus.lane_pc[1]     = 32'h80004004;
    bus.lane_branch[1] = 1'b1;
    #1;
    checks++; if (bus.commit !== 2'b10) begin errors++; $display("FAIL pb_commit got=%b exp=10", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL pb_flush got=%b exp=0", bus.flush); end
    checks++; if (bus.last_pc !== 32'h80004004) begin errors++; $display("FAIL pb_last_pc got=%h exp=80004004", bus.last_pc); end
    @(negedge clk);
    clear_lanes();
    bus.lane_valid = 2'b01;
    bus.lane_pc[0] = 32'h80004008;
    bus.lane_etype[0].overflow = 1'b1;
    #1;
    checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL pb_ov_commit got=%b exp=00", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.is_slot !== 1'b1) begin errors++; $display("FAIL pb_slot got=%b exp=1", bus.is_slot); end
    checks++; if (bus.pc !== 32'h80004008) begin errors++; $display("FAIL pb_pc got=%h exp=80004008", bus.pc); end
    checks++; if (bus.etype.overflow !== 1'b1) begin errors++; $display("FAIL pb_ov got=%b exp=1", bus.etype.overflow); end
    drain();
  endtask

  task automatic test_int_priority();
    @(negedge clk);
    bus.is_int     = 1'b1;
    bus.lane_valid = 2'b11;
    bus.lane_pc[0] = 32'h80005000;
    bus.lane_pc[1] = 32'h80005004;
    bus.lane_etype[0].badVaddrF = 1'b1;
    #1;
    checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL int_commit got=%b exp=00", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.inter_valid !== 1'b1) begin errors++; $display("FAIL int_valid got=%b exp=1", bus.inter_valid); end
    checks++; if (bus.int_pc !== 32'h80005000) begin errors++; $display("FAIL int_pc got=%h exp=80005000", bus.int_pc); end
    checks++; if (bus.int_slot !== 1'b0) begin errors++; $display("FAIL int_slot got=%b exp=0", bus.int_slot); end
    checks++; if (bus.ctype !== NONE) begin errors++; $display("FAIL int_ctype got=%0d exp=%0d", bus.ctype, NONE); end
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL int_flush got=%b exp=1", bus.flush); end
    checks++; if (bus.redirect_pc !== ENTRANCE) begin errors++; $display("FAIL int_redirect got=%h exp=%h", bus.redirect_pc, ENTRANCE); end
    drain();
  endtask

  task automatic test_stall_int();
    @(negedge clk);
    bus.stall      = 1'b1;
    bus.is_int     = 1'b1;
    bus.lane_valid = 2'b01;
    bus.lane_pc[0] = 32'h80007000;
    #1;
    checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL stall_commit got=%b exp=00", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.inter_valid !== 1'b0) begin errors++; $display("FAIL stall_int got=%b exp=0", bus.inter_valid); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL stall_flush got=%b exp=0", bus.flush); end
    @(negedge clk);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.inter_valid !== 1'b1) begin errors++; $display("FAIL stall_int_late got=%b exp=1", bus.inter_valid); end
    checks++; if (bus.int_pc !== 32'h80007000) begin errors++; $display("FAIL stall_int_pc got=%h exp=80007000", bus.int_pc); end
    drain();
  endtask

  task automatic test_drain();
    @(negedge clk);
    bus.lane_valid = 2'b01;
    bus.lane_pc[0] = 32'h80008000;
    bus.lane_etype[0].syscall = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.lane_valid = 2'b11;
      bus.lane_dtlb[1].invalid = 1'b1;
      #1;
      checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL drain_commit[%0d] got=%b exp=00", i, bus.commit); end
      @(posedge clk); #1;
      checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL drain_flush[%0d] got=%b exp=0", i, bus.flush); end
      checks++; if (bus.ctype !== NONE) begin errors++; $display("FAIL drain_ctype[%0d] got=%0d exp=%0d", i, bus.ctype, NONE); end
    end
    @(negedge clk);
    clear_lanes();
    bus.lane_valid = 2'b11;
    bus.lane_pc[0] = 32'h80008100;
    bus.lane_pc[1] = 32'h80008104;
    #1;
    checks++; if (bus.commit !== 2'b11) begin errors++; $display("FAIL drain_resume got=%b exp=11", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.last_pc !== 32'h80008104) begin errors++; $display("FAIL drain_last_pc got=%h exp=80008104", bus.last_pc); end
    clear_lanes();
  endtask

  task automatic test_eret();
    @(negedge clk);
    bus.lane_valid   = 2'b11;
    bus.lane_pc[0]   = 32'h80006000;
    bus.lane_pc[1]   = 32'h80006004;
    bus.lane_eret[0] = 1'b1;
    #1;
    checks++; if (bus.commit !== 2'b01) begin errors++; $display("FAIL eret_commit got=%b exp=01", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.is_eret !== 1'b1) begin errors++; $display("FAIL eret_flag got=%b exp=1", bus.is_eret); end
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL eret_flush got=%b exp=1", bus.flush); end
    checks++; if (bus.redirect_pc !== EPC_V) begin errors++; $display("FAIL eret_redirect got=%h exp=%h", bus.redirect_pc, EPC_V); end
    checks++; if (bus.ctype !== NONE) begin errors++; $display("FAIL eret_ctype got=%0d exp=%0d", bus.ctype, NONE); end
    checks++; if (bus.last_pc !== 32'h80006000) begin errors++; $display("FAIL eret_last_pc got=%h exp=80006000", bus.last_pc); end
    drain();
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    bus.lane_valid = 2'b01;
    bus.lane_pc[0] = 32'h80009000;
    bus.lane_etype[0].syscall = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL mid_flush got=%b exp=1", bus.flush); end
    @(negedge clk);
    clear_lanes();
    bus.lane_valid = 2'b11;
    bus.lane_pc[0] = 32'h8000a000;
    bus.lane_pc[1] = 32'h8000a004;
    reset = 1'b0;
    #1;
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL mid_rst_flush got=%b exp=0", bus.flush); end
    checks++; if (bus.ctype !== NONE) begin errors++; $display("FAIL mid_rst_ctype got=%0d exp=%0d", bus.ctype, NONE); end
    checks++; if (bus.commit !== 2'b00) begin errors++; $display("FAIL mid_rst_commit got=%b exp=00", bus.commit); end
    checks++; if (bus.last_pc !== RST_PC) begin errors++; $display("FAIL mid_rst_last_pc got=%h exp=%h", bus.last_pc, RST_PC); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.commit !== 2'b11) begin errors++; $display("FAIL mid_rel_commit got=%b exp=11", bus.commit); end
    @(posedge clk); #1;
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL mid_rel_flush got=%b exp=0", bus.flush); end
    checks++; if (bus.last_pc !== 32'h8000a004) begin errors++; $display("FAIL mid_rel_last_pc got=%h exp=8000a004", bus.last_pc); end
    clear_lanes();
  endtask

  initial begin
    test_reset();
    test_exc_lane0();
    test_lane1_slot();
    test_prev_branch();
    test_int_priority();
    test_stall_int();
    test_drain();
    test_eret();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
